audio_filter_sched: RTL and testbench

Frame scheduler for the shared comb/DC-removal filter engine. On each PCM strobe it snapshots the integrator outputs of all PDM channels and runs `audio_filter` once per channel, in order. Each channel uses its own slice of the filter state RAM. The block zeroes that RAM after reset and owns the RAM write-port mux. It publishes a double-buffered set of 16-bit PCM samples with a one-cycle valid strobe. It sits between the `cic_integrator` instances plus `audio_clk_gen` on one side and the I2S/PWM output stage on the other.

---
 rtl/audio_filter_sched_pkg.sv | 20 ++
 rtl/audio_filter_sched_if.sv | 30 +++
 rtl/audio_filter_sched_ram_clear_walker.sv | 32 +++
 rtl/audio_filter_sched.sv | 140 ++++++++++++++
 tb/tb_audio_filter_sched.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_filter_sched_pkg.sv
// Shared types and widths for the audio filter frame scheduler.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package audio_pkg;

    localparam int SAMPLE_W       = 24;
    localparam int PCM_W          = 16;
    localparam int DEFAULT_STRIDE = 8;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_STORE,
        ST_PUBLISH
    } sched_state_t;

endpackage

// File: rtl/audio_filter_sched_if.sv
// Scheduler <-> filter engine handshake: start/busy control, operands, result, RAM write request.
// Latency: wires only.
// Backpressure: filter signals completion by a busy high-then-low sequence; no ready/valid.
interface audio_filter_sched_if #(
    parameter int AW = 10
);
    import audio_pkg::*;

    logic                filt_start;
    logic [AW-1:0]       filt_addr_start;
    logic [SAMPLE_W-1:0] filt_din;
    logic                filt_busy;
    logic [PCM_W-1:0]    filt_out;
    logic                filt_wr_en;
    logic [AW-1:0]       filt_wr_addr;
    logic [SAMPLE_W-1:0] filt_wr_data;

    // Scheduler side
    modport master (
        output filt_start, filt_addr_start, filt_din,
        input  filt_busy, filt_out, filt_wr_en, filt_wr_addr, filt_wr_data
    );

    // Filter engine side
    modport slave (
        input  filt_start, filt_addr_start, filt_din,
        output filt_busy, filt_out, filt_wr_en, filt_wr_addr, filt_wr_data
    );

endinterface

// File: rtl/audio_filter_sched_ram_clear_walker.sv
// Walks RAM addresses 0..DEPTH-1 one per enabled cycle, then raises a sticky done flag.
// Latency: last is combinational on the current address; done rises the cycle after last.
// Backpressure: none; advances every cycle en is high until done.
module ram_clear_walker #(
    parameter int AW    = 10,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          done
);

    assign last = (addr == AW'(DEPTH - 1));

    // Address counter; it parks on the final address once done is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            done <= 1'b0;
        end else if (en && !done) begin
            if (last) begin
                done <= 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_filter_sched.sv
// Frame scheduler: zeroes filter RAM, then per PCM strobe runs the shared filter over each channel and publishes PCM.
// Latency: per channel START + filter busy pulse + STORE; pcm_valid one cycle after the last STORE.
// Backpressure: none; a strobe arriving while a frame is in flight is dropped and flagged as overrun.
module audio_filter_sched
    import audio_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int STRIDE = DEFAULT_STRIDE,
    parameter int AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stb_pcm,
    input  logic [SAMPLE_W*NCH-1:0] ch_din,
    audio_filter_sched_if.master    filt,
    output logic                    ram_wr_en,
    output logic [AW-1:0]           ram_wr_addr,
    output logic [SAMPLE_W-1:0]     ram_wr_data,
    output logic [PCM_W*NCH-1:0]    pcm,
    output logic                    pcm_valid,
    output logic                    ready,
    output logic                    overrun
);

    localparam int DEPTH = NCH * STRIDE;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

    sched_state_t        state, state_nxt;
    logic [CHW-1:0]      ch;
    logic [SAMPLE_W-1:0] snap   [NCH];
    logic [PCM_W-1:0]    shadow [NCH];
    logic [AW-1:0]       clr_addr;
    logic                clr_last;
    logic                ch_last;

    assign ch_last = (ch == CHW'(NCH - 1));

    ram_clear_walker #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_clear (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_CLEAR),
        .addr (clr_addr),
        .last (clr_last),
        .done (ready)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; strobes are only acted on in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR:   if (clr_last) state_nxt = ST_IDLE;
            ST_IDLE:    if (stb_pcm) state_nxt = ST_START;
            ST_START:   state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (filt.filt_busy) state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!filt.filt_busy) state_nxt = ST_STORE;
            ST_STORE:   state_nxt = ch_last ? ST_PUBLISH : ST_START;
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_CLEAR;
        endcase
    end

    // Filter operands follow the channel index, which only moves on STORE -> START,
    // so they stay stable from START through STORE
    always_comb begin
        filt.filt_start      = (state == ST_START);
        filt.filt_addr_start = AW'(AW'(ch) * AW'(STRIDE));
        filt.filt_din        = snap[ch];
        pcm_valid            = (state == ST_PUBLISH);
    end

    // RAM write-port mux: the clear walker owns the port in CLEAR, filter writes pass through otherwise
    always_comb begin
        ram_wr_en   = filt.filt_wr_en;
        ram_wr_addr = filt.filt_wr_addr;
        ram_wr_data = filt.filt_wr_data;
        if (state == ST_CLEAR) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = clr_addr;
            ram_wr_data = '0;
        end
    end

    // Snapshot capture, channel sequencing and result shadows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
            for (int i = 0; i < NCH; i++) begin
                snap[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (state == ST_IDLE && stb_pcm) begin
                ch <= '0;
                for (int i = 0; i < NCH; i++) begin
                    snap[i] <= ch_din[i*SAMPLE_W +: SAMPLE_W];
                end
            end
            if (state == ST_STORE) begin
                shadow[ch] <= filt.filt_out;
                if (!ch_last) begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

    // Published buffer: loaded on the last STORE (last channel taken straight from the
    // filter) so the new samples are already on pcm during the PUBLISH cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcm <= '0;
        end else if (state == ST_STORE && ch_last) begin
            for (int i = 0; i < NCH; i++) begin
                pcm[i*PCM_W +: PCM_W] <= (i == NCH - 1) ? filt.filt_out : shadow[i];
            end
        end
    end

    // Sticky overrun on any strobe that arrives while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (stb_pcm && state != ST_IDLE && state != ST_CLEAR) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_filter_sched.sv
// Testbench for audio_filter_sched: behavioural filter, randomized frames, scoreboard of expected outputs.
// Latency: filter model holds busy for LAT cycles after each start pulse.
// Backpressure: n/a.
module tb_audio_filter_sched;
    import audio_pkg::*;

    localparam int NCH       = 2;
    localparam int STRIDE    = 8;
    localparam int AW        = 10;
    localparam int DEPTH     = NCH * STRIDE;
    localparam int LAT       = 30;
    // per channel: START, WAIT_HI, LAT WAIT_LO cycles, STORE; then PUBLISH
    localparam int FRAME_LAT = NCH * (LAT + 3) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stb_pcm;
    logic [SAMPLE_W*NCH-1:0] ch_din;
    logic                    ram_wr_en;
    logic [AW-1:0]           ram_wr_addr;
    logic [SAMPLE_W-1:0]     ram_wr_data;
    logic [PCM_W*NCH-1:0]    pcm;
    logic                    pcm_valid;
    logic                    ready;
    logic                    overrun;

    audio_filter_sched_if #(.AW(AW)) fif ();

    audio_filter_sched #(.NCH(NCH), .STRIDE(STRIDE), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stb_pcm     (stb_pcm),
        .ch_din      (ch_din),
        .filt        (fif),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .pcm         (pcm),
        .pcm_valid   (pcm_valid),
        .ready       (ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int pv_cnt = 0;
    int exp_pv = 0;
    int stb_cyc = 0;
    bit frame_active = 0;
    logic exp_overrun = 1'b0;
    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_din_q[$];
    logic [63:0] exp_pcm_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural filter: on start, busy for LAT cycles, then result = din[15:0]
    logic [SAMPLE_W-1:0] f_din;
    int f_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_cnt         <= 0;
            f_din         <= '0;
            fif.filt_busy <= 1'b0;
            fif.filt_out  <= '0;
        end else if (fif.filt_start) begin
            f_din         <= fif.filt_din;
            f_cnt         <= LAT;
            fif.filt_busy <= 1'b1;
        end else if (f_cnt != 0) begin
            f_cnt <= f_cnt - 1;
            if (f_cnt == 1) begin
                fif.filt_busy <= 1'b0;
                fif.filt_out  <= f_din[15:0];
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a start or a published frame
    always @(negedge clk) begin
        if (!rst) begin
            if (fif.filt_start) begin
                start_cnt++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got start addr %0h expected no start", fif.filt_addr_start);
                end else begin
                    chk("filt_addr_start", 64'(fif.filt_addr_start), exp_addr_q.pop_front());
                    chk("filt_din", 64'(fif.filt_din), exp_din_q.pop_front());
                end
            end
            if (pcm_valid) begin
                pv_cnt++;
                if (exp_pcm_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pcm_valid: got pcm %0h expected no pulse", pcm);
                end else begin
                    chk("pcm", 64'(pcm), exp_pcm_q.pop_front());
                    chk("frame_latency", 64'(cyc - stb_cyc), 64'(FRAME_LAT));
                    chk("overrun_at_publish", 64'(overrun), 64'(exp_overrun));
                end
                frame_active = 0;
            end
        end
    end

    // Issue one accepted frame; expectations come straight from the channel values
    task automatic send_frame(input logic [SAMPLE_W*NCH-1:0] v);
        logic [PCM_W*NCH-1:0] p;
        tick();
        ch_din  = v;
        stb_pcm = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            exp_addr_q.push_back(64'(i * STRIDE));
            exp_din_q.push_back(64'(v[i*SAMPLE_W +: SAMPLE_W]));
            p[i*PCM_W +: PCM_W] = v[i*SAMPLE_W +: PCM_W];
        end
        exp_pcm_q.push_back(64'(p));
        exp_pv++;
        frame_active = 1;
        stb_cyc = cyc;
        tick();
        stb_pcm = 1'b0;
        ch_din  = {$urandom, $urandom};   // snapshot must not follow live inputs
    endtask

    task automatic wait_frame_done();
        int n;
        n = 0;
        while (frame_active && n < 1000) begin
            tick();
            n++;
        end
        if (frame_active) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no pcm_valid in %0d cycles expected one", n);
            frame_active = 0;
        end
    endtask

    task automatic reset_values();
        @(negedge clk);
        chk("rst_filt_start", 64'(fif.filt_start), 0);
        chk("rst_pcm_valid", 64'(pcm_valid), 0);
        chk("rst_ready", 64'(ready), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_pcm", 64'(pcm), 0);
        chk("rst_filt_addr_start", 64'(fif.filt_addr_start), 0);
        chk("rst_filt_din", 64'(fif.filt_din), 0);
        chk("rst_ram_wr_en", 64'(ram_wr_en), 1);
    endtask

    // Release reset and follow the clear walk; a strobe and a filter write land mid-clear
    task automatic clear_check();
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("clr_wr_en", 64'(ram_wr_en), 1);
            chk("clr_addr", 64'(ram_wr_addr), 64'(i));
            chk("clr_data", 64'(ram_wr_data), 0);
            chk("clr_ready", 64'(ready), 0);
            if (i == 5) begin
                stb_pcm          = 1'b1;
                fif.filt_wr_en   = 1'b1;
                fif.filt_wr_addr = 10'd3;
                fif.filt_wr_data = 24'hABCDEF;
            end else if (i == 6) begin
                stb_pcm        = 1'b0;
                fif.filt_wr_en = 1'b0;
            end
        end
        @(negedge clk);
        chk("ready_after_clear", 64'(ready), 1);
        chk("wr_en_after_clear", 64'(ram_wr_en), 0);
        chk("overrun_after_clear", 64'(overrun), 0);
    endtask

    initial begin
        int base;
        int n;
        rst              = 1'b0;
        stb_pcm          = 1'b0;
        ch_din           = '0;
        fif.filt_wr_en   = 1'b0;
        fif.filt_wr_addr = '0;
        fif.filt_wr_data = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        reset_values();
        clear_check();

        // Directed frame: ch0=0x000100, ch1=0xFFFF00
        send_frame({24'hFFFF00, 24'h000100});
        wait_frame_done();

        // Filter write pass-through in IDLE
        tick();
        fif.filt_wr_en   = 1'b1;
        fif.filt_wr_addr = 10'd3;
        fif.filt_wr_data = 24'h123456;
        @(negedge clk);
        chk("pass_en", 64'(ram_wr_en), 1);
        chk("pass_addr", 64'(ram_wr_addr), 3);
        chk("pass_data", 64'(ram_wr_data), 64'h123456);
        for (int k = 0; k < 3; k++) begin
            logic [AW-1:0]       a;
            logic [SAMPLE_W-1:0] d;
            a = AW'($urandom);
            d = SAMPLE_W'($urandom);
            tick();
            fif.filt_wr_addr = a;
            fif.filt_wr_data = d;
            @(negedge clk);
            chk("pass_rand_addr", 64'(ram_wr_addr), 64'(a));
            chk("pass_rand_data", 64'(ram_wr_data), 64'(d));
        end
        tick();
        fif.filt_wr_en = 1'b0;

        // Directed overrun 10 cycles into a frame
        send_frame({SAMPLE_W'($urandom), SAMPLE_W'($urandom)});
        repeat (8) tick();
        stb_pcm = 1'b1;
        exp_overrun = 1'b1;
        tick();
        stb_pcm = 1'b0;
        wait_frame_done();
        repeat (5) tick();

        // Randomized frames, some with a dropped strobe
        for (int f = 0; f < 12; f++) begin
            repeat ($urandom_range(1, 20)) tick();
            send_frame({SAMPLE_W'($urandom), SAMPLE_W'($urandom)});
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(3, 50)) tick();
                stb_pcm = 1'b1;
                exp_overrun = 1'b1;
                tick();
                stb_pcm = 1'b0;
            end
            wait_frame_done();
        end
        repeat (5) tick();
        chk("pcm_valid_count", 64'(pv_cnt), 64'(exp_pv));

        // Reset while channel 1 is inside the filter
        base = start_cnt;
        send_frame({SAMPLE_W'($urandom), SAMPLE_W'($urandom)});
        n = 0;
        while (start_cnt < base + 2 && n < 200) begin
            tick();
            n++;
        end
        chk("ch1_started", 64'(start_cnt >= base + 2), 1);
        repeat (5) tick();
        chk("busy_before_reset", 64'(fif.filt_busy), 1);
        rst = 1'b1;
        exp_addr_q.delete();
        exp_din_q.delete();
        exp_pcm_q.delete();
        exp_pv--;
        frame_active = 0;
        exp_overrun = 1'b0;
        reset_values();
        clear_check();

        // Recovery frame after the aborted one
        send_frame({SAMPLE_W'($urandom), SAMPLE_W'($urandom)});
        wait_frame_done();
        repeat (5) tick();
        chk("pcm_valid_count_final", 64'(pv_cnt), 64'(exp_pv));
        chk("queues_drained", 64'(exp_addr_q.size() + exp_pcm_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
